// File: rtl/wb_sysa_engine.sv
// wb_sysa_engine
// Wishbone-mapped N x N weight-stationary matrix-vector engine.
// Software loads the weight matrix row-major through WEIGHT and queues input
// elements through INPUT (into a FIFO). A start on CTRL pops N elements, runs
// N multiply-accumulate steps across N lanes and buffers N results for reads
// through RESULT.
//
// Ports
//   caravel_wb_clk_i    single clock, rising edge
//   caravel_wb_rst_n_i  asynchronous active-low reset
//   caravel_wb_stb_i / caravel_wb_cyc_i / caravel_wb_we_i  Wishbone classic controls
//   caravel_wb_sel_i    byte select (ignored, full-word accesses only)
//   caravel_wb_adr_i    byte address; 32-byte window at BASE_ADDRESS
//   caravel_wb_dat_i    write data
//   caravel_wb_ack_o    registered one-cycle acknowledge
//   caravel_wb_dat_o    registered read data
//   irq_o               level interrupt, high while STATUS.done is set
module wb_sysa_engine #(
  parameter int          ARRAY_SIZE   = 3,
  parameter int          DATA_W       = 8,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_n_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_adr_i,
  input  logic [31:0] caravel_wb_dat_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o,
  output logic        irq_o
);

  localparam int ACC_W  = 2 * DATA_W + $clog2(ARRAY_SIZE);
  localparam int NN     = ARRAY_SIZE * ARRAY_SIZE;
  localparam int CNT_W  = $clog2(ARRAY_SIZE);
  localparam int WIDX_W = $clog2(NN);
  localparam int FPTR_W = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = FPTR_W + 1;
  localparam int RCNT_W = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MAC   = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  // Unsigned product widened to the accumulator width before multiplying.
  function automatic logic [ACC_W-1:0] mul_u(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    mul_u = ACC_W'(a) * ACC_W'(b);
  endfunction

  // ---------------------------------------------------------------- state
  logic              ack_r;
  logic [31:0]       dat_r;

  logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [FPTR_W-1:0] fifo_wptr_r;
  logic [FPTR_W-1:0] fifo_rptr_r;
  logic [FCNT_W-1:0] fifo_cnt_r;
  logic              overflow_r;

  logic [DATA_W-1:0] w_r [NN];
  logic [WIDX_W-1:0] widx_r;
  logic              wgt_err_r;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] x_r   [ARRAY_SIZE];
  logic [ACC_W-1:0]  acc_r [ARRAY_SIZE];
  logic [ACC_W-1:0]  res_r [ARRAY_SIZE];
  logic [CNT_W-1:0]  res_rptr_r;
  logic [RCNT_W-1:0] res_cnt_r;
  logic              done_r;
  logic              start_err_r;
  logic              start_cmd_r;

  // ---------------------------------------------------------------- decode
  logic        in_window_s, req_s, wr_s, rd_s;
  logic [2:0]  reg_sel_s;
  logic        ctrl_wr_s, srst_s, start_wr_s, wgt_wr_s, in_wr_s, res_rd_s;
  logic        busy_s, fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [31:0] status_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  assign in_window_s = (caravel_wb_adr_i[31:5] == BASE_ADDRESS[31:5]);
  // A request is taken only while ack is low so each access acts exactly once.
  assign req_s       = caravel_wb_stb_i & caravel_wb_cyc_i & in_window_s & ~ack_r;
  assign wr_s        = req_s & caravel_wb_we_i;
  assign rd_s        = req_s & ~caravel_wb_we_i;
  assign reg_sel_s   = caravel_wb_adr_i[4:2];

  assign ctrl_wr_s   = wr_s & (reg_sel_s == 3'd0);
  // soft_clear is the block's synchronous reset; it overrides a start in the same write.
  assign srst_s      = ctrl_wr_s & caravel_wb_dat_i[1];
  assign start_wr_s  = ctrl_wr_s & caravel_wb_dat_i[0] & ~caravel_wb_dat_i[1];
  assign wgt_wr_s    = wr_s & (reg_sel_s == 3'd2);
  assign in_wr_s     = wr_s & (reg_sel_s == 3'd3);
  assign res_rd_s    = rd_s & (reg_sel_s == 3'd4);

  assign busy_s       = (state_r != ST_IDLE);
  assign fifo_full_s  = (fifo_cnt_r == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty_s = (fifo_cnt_r == FCNT_W'(0));
  assign push_s       = in_wr_s & ~fifo_full_s;
  assign pop_s        = (state_r == ST_LOAD) & ~fifo_empty_s;

  assign status_s = {8'h00, 8'(res_cnt_r), 8'(fifo_cnt_r), 1'b0, wgt_err_r,
                     start_err_r, overflow_r, fifo_empty_s, fifo_full_s,
                     done_r, busy_s};

  assign unused_s = ^{caravel_wb_sel_i, caravel_wb_adr_i[1:0],
                      caravel_wb_dat_i[31:DATA_W]};

  // Read-data mux; RESULT returns the entry under the read pointer before it advances.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (reg_sel_s)
      3'd1: rd_data_s = status_s;
      3'd4: begin
        if (res_cnt_r != RCNT_W'(0)) begin
          rd_data_s = 32'(res_r[res_rptr_r]);
        end else begin
          rd_data_s = 32'h0000_0000;
        end
      end
      default: rd_data_s = 32'h0000_0000;
    endcase
  end

  // Wishbone ack pulse and registered read data.
  always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
    if (!caravel_wb_rst_n_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= req_s;
      if (rd_s) begin
        dat_r <= rd_data_s;
      end
    end
  end

  // Input FIFO: pushes from the bus, pops by the engine in LOAD; a full FIFO drops writes.
  always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
    if (!caravel_wb_rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {DATA_W{1'b0}};
      end
      fifo_wptr_r <= FPTR_W'(0);
      fifo_rptr_r <= FPTR_W'(0);
      fifo_cnt_r  <= FCNT_W'(0);
      overflow_r  <= 1'b0;
    end else if (srst_s) begin
      fifo_wptr_r <= FPTR_W'(0);
      fifo_rptr_r <= FPTR_W'(0);
      fifo_cnt_r  <= FCNT_W'(0);
      overflow_r  <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[fifo_wptr_r] <= caravel_wb_dat_i[DATA_W-1:0];
        fifo_wptr_r             <= fifo_wptr_r + FPTR_W'(1);
      end
      if (pop_s) begin
        fifo_rptr_r <= fifo_rptr_r + FPTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + FCNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - FCNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      if (in_wr_s && fifo_full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Weight memory; soft_clear rewinds the write index but keeps the matrix.
  always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
    if (!caravel_wb_rst_n_i) begin
      for (int i = 0; i < NN; i++) begin
        w_r[i] <= {DATA_W{1'b0}};
      end
      widx_r    <= WIDX_W'(0);
      wgt_err_r <= 1'b0;
    end else if (srst_s) begin
      widx_r    <= WIDX_W'(0);
      wgt_err_r <= 1'b0;
    end else if (wgt_wr_s) begin
      if (busy_s) begin
        wgt_err_r <= 1'b1;
      end else begin
        w_r[widx_r] <= caravel_wb_dat_i[DATA_W-1:0];
        widx_r      <= (widx_r == WIDX_W'(NN - 1)) ? WIDX_W'(0) : widx_r + WIDX_W'(1);
      end
    end
  end

  // Engine FSM with its datapath and result buffer.
  // The accepted start is registered once so that done lands 2N+2 cycles after the ack.
  always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
    if (!caravel_wb_rst_n_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_W'(0);
      res_rptr_r  <= CNT_W'(0);
      res_cnt_r   <= RCNT_W'(0);
      done_r      <= 1'b0;
      start_err_r <= 1'b0;
      start_cmd_r <= 1'b0;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
        x_r[j]   <= {DATA_W{1'b0}};
        acc_r[j] <= {ACC_W{1'b0}};
        res_r[j] <= {ACC_W{1'b0}};
      end
    end else if (srst_s) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_W'(0);
      res_rptr_r  <= CNT_W'(0);
      res_cnt_r   <= RCNT_W'(0);
      done_r      <= 1'b0;
      start_err_r <= 1'b0;
      start_cmd_r <= 1'b0;
    end else begin
      start_cmd_r <= start_wr_s;
      case (state_r)
        ST_IDLE: begin
          if (start_cmd_r) begin
            if (fifo_cnt_r >= FCNT_W'(ARRAY_SIZE)) begin
              state_r <= ST_LOAD;
              cnt_r   <= CNT_W'(0);
              done_r  <= 1'b0;
              for (int j = 0; j < ARRAY_SIZE; j++) begin
                acc_r[j] <= {ACC_W{1'b0}};
              end
            end else begin
              start_err_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          x_r[cnt_r] <= fifo_mem_r[fifo_rptr_r];
          if (cnt_r == CNT_W'(ARRAY_SIZE - 1)) begin
            cnt_r   <= CNT_W'(0);
            state_r <= ST_MAC;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_MAC: begin
          // Step k: every lane j adds W[j][k] * x[k].
          for (int j = 0; j < ARRAY_SIZE; j++) begin
            acc_r[j] <= acc_r[j] +
                        mul_u(w_r[WIDX_W'(j * ARRAY_SIZE) + WIDX_W'(cnt_r)], x_r[cnt_r]);
          end
          if (cnt_r == CNT_W'(ARRAY_SIZE - 1)) begin
            cnt_r   <= CNT_W'(0);
            state_r <= ST_STORE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_STORE: begin
          for (int j = 0; j < ARRAY_SIZE; j++) begin
            res_r[j] <= acc_r[j];
          end
          res_cnt_r  <= RCNT_W'(ARRAY_SIZE);
          res_rptr_r <= CNT_W'(0);
          done_r     <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
      // STORE owns the result pointer in its cycle; a coincident read is not consumed.
      if (res_rd_s && (res_cnt_r != RCNT_W'(0)) && (state_r != ST_STORE)) begin
        res_rptr_r <= res_rptr_r + CNT_W'(1);
        res_cnt_r  <= res_cnt_r - RCNT_W'(1);
      end
    end
  end

  assign caravel_wb_ack_o = ack_r;
  assign caravel_wb_dat_o = dat_r;
  assign irq_o            = done_r;

endmodule

// File: tb/tb_wb_sysa_engine.sv
// Self-checking bench for wb_sysa_engine (N=3, DATA_W=8, FIFO_DEPTH=16).
module tb_wb_sysa_engine;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_WEIGHT = 32'h08,
                          A_INPUT = 32'h0C, A_RESULT = 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 32'h0, dat_i = 32'h0;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  wb_sysa_engine dut (
    .caravel_wb_clk_i  (clk),
    .caravel_wb_rst_n_i(rst_n),
    .caravel_wb_stb_i  (stb),
    .caravel_wb_cyc_i  (cyc),
    .caravel_wb_we_i   (we),
    .caravel_wb_sel_i  (sel),
    .caravel_wb_adr_i  (adr),
    .caravel_wb_dat_i  (dat_i),
    .caravel_wb_ack_o  (ack),
    .caravel_wb_dat_o  (dat_o),
    .irq_o             (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][7:0]  w;
    logic [2:0][7:0]  x;
    logic [2:0][31:0] y;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
    bit got = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + off; dat_i = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) check("write_ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] d);
    bit got = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + off;
    d = 32'hDEAD_BEEF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; d = dat_o; end
    end
    stb = 1'b0; cyc = 1'b0;
    if (!got) check("read_ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(A_STATUS, d);
    check(name, d, exp);
  endtask

  // Pop the scoreboard's next expected RESULT value and compare against a bus read.
  task automatic read_result();
    logic [31:0] d;
    wb_read(A_RESULT, d);
    if (exp_q.size() == 0) begin
      check("result_unexpected", d, 32'hFFFF_FFFF);
    end else begin
      check("result", d, exp_q.pop_front());
    end
  endtask

  task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
  endtask

  task automatic write_inputs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    wb_write(A_INPUT, a); wb_write(A_INPUT, b); wb_write(A_INPUT, c);
  endtask

  task automatic load_identity();
    for (int k = 0; k < 9; k++) wb_write(A_WEIGHT, (k % 4 == 0) ? 32'd1 : 32'd0);
  endtask

  // Cycles from the ack edge until irq is seen; 99 if it never arrives.
  task automatic wait_irq(output int n);
    n = 99;
    for (int i = 1; i <= 40 && n == 99; i++) begin
      @(posedge clk); #1;
      if (irq) n = i;
    end
  endtask

  task automatic start_and_wait();
    int n;
    wb_write(A_CTRL, 32'h1);
    wait_irq(n);
    check("done_latency", 32'(n), 32'd8);
  endtask

  initial begin
    logic [31:0] d;
    int acks;

    for (int k = 0; k < 9; k++) begin
      tbl[0].w[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      tbl[1].w[k] = 8'd255;
      tbl[2].w[k] = 8'(k + 1);
    end
    tbl[3].w = {8'd1, 8'd1, 8'd1, 8'd0, 8'd3, 8'd0, 8'd1, 8'd0, 8'd2};
    tbl[0].x = {8'd3, 8'd2, 8'd1};       tbl[0].y = {32'd3, 32'd2, 32'd1};
    tbl[1].x = {8'd255, 8'd255, 8'd255}; tbl[1].y = {32'h2FA03, 32'h2FA03, 32'h2FA03};
    tbl[2].x = {8'd2, 8'd0, 8'd1};       tbl[2].y = {32'd25, 32'd16, 32'd7};
    tbl[3].x = {8'd30, 8'd20, 8'd10};    tbl[3].y = {32'd60, 32'd60, 32'd50};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_status("rst_status", 32'h0000_0008);
    exp_q.push_back(32'h0);
    read_result();

    // Outside the window: no ack
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h20; dat_i = 32'h1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("oow_no_ack", 32'(acks), 32'h0);
    wb_read(32'h14, d);
    check("reserved_read", d, 32'h0);

    // Table-driven matrix-vector runs
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 9; k++) wb_write(A_WEIGHT, 32'(tbl[t].w[k]));
      write_inputs(32'(tbl[t].x[0]), 32'(tbl[t].x[1]), 32'(tbl[t].x[2]));
      push3(tbl[t].y[0], tbl[t].y[1], tbl[t].y[2]);
      exp_q.push_back(32'h0);
      start_and_wait();
      check("irq_high", 32'(irq), 32'h1);
      check_status("status_done", 32'h0003_000A);
      for (int r = 0; r < 4; r++) read_result();
    end

    // FIFO overflow: 17 writes, the 17th is dropped
    load_identity();
    for (int v = 1; v <= 17; v++) wb_write(A_INPUT, 32'(v));
    check_status("status_overflow", 32'h0000_1016);
    for (int r = 0; r < 5; r++) begin
      push3(32'(3 * r + 1), 32'(3 * r + 2), 32'(3 * r + 3));
      start_and_wait();
      for (int k = 0; k < 3; k++) read_result();
    end
    wb_write(A_INPUT, 32'd100);
    wb_write(A_INPUT, 32'd101);
    push3(32'd16, 32'd100, 32'd101);
    start_and_wait();
    for (int k = 0; k < 3; k++) read_result();

    // Start with too few inputs
    wb_write(A_CTRL, 32'h2);
    check_status("status_after_clear", 32'h0000_0008);
    wb_write(A_INPUT, 32'd40);
    wb_write(A_INPUT, 32'd41);
    wb_write(A_CTRL, 32'h1);
    repeat (3) @(posedge clk);
    check_status("status_start_err", 32'h0000_0220);
    wb_write(A_INPUT, 32'd42);
    push3(32'd40, 32'd41, 32'd42);
    start_and_wait();
    for (int k = 0; k < 3; k++) read_result();

    // soft_clear during MAC, then a clean run with the retained weights
    wb_write(A_CTRL, 32'h2);
    write_inputs(32'd7, 32'd8, 32'd9);
    wb_write(A_CTRL, 32'h1);
    repeat (4) @(posedge clk);
    wb_write(A_CTRL, 32'h2);
    check_status("status_abort", 32'h0000_0008);
    check("abort_irq", 32'(irq), 32'h0);
    write_inputs(32'd11, 32'd12, 32'd13);
    push3(32'd11, 32'd12, 32'd13);
    start_and_wait();
    for (int k = 0; k < 3; k++) read_result();

    // start and soft_clear together: nothing starts
    write_inputs(32'd1, 32'd2, 32'd3);
    wb_write(A_CTRL, 32'h3);
    repeat (3) @(posedge clk);
    check_status("status_start_clear", 32'h0000_0008);

    // WEIGHT write while busy is discarded
    write_inputs(32'd5, 32'd6, 32'd7);
    begin
      int n;
      wb_write(A_CTRL, 32'h1);
      repeat (2) @(posedge clk);
      wb_write(A_WEIGHT, 32'd99);
      wait_irq(n);
      check("wgt_run_done", 32'(n < 99), 32'h1);
    end
    check_status("status_wgt_err", 32'h0003_004A);
    push3(32'd5, 32'd6, 32'd7);
    for (int k = 0; k < 3; k++) read_result();
    write_inputs(32'd8, 32'd9, 32'd10);
    push3(32'd8, 32'd9, 32'd10);
    start_and_wait();
    for (int k = 0; k < 3; k++) read_result();

    // Asynchronous reset in the middle of LOAD
    write_inputs(32'd1, 32'd2, 32'd3);
    wb_write(A_CTRL, 32'h1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(ack), 32'h0);
    check("arst_dat", dat_o, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_status("arst_status", 32'h0000_0008);
    exp_q.push_back(32'h0);
    read_result();
    // Weights were zeroed by reset
    write_inputs(32'd4, 32'd5, 32'd6);
    push3(32'd0, 32'd0, 32'd0);
    start_and_wait();
    for (int k = 0; k < 3; k++) read_result();

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_sysa_engine.md
WB_SYSA_ENGINE -- requirements
Module: wb_sysa_engine

Interface
REQ-001 Parameter ARRAY_SIZE, default 3: matrix dimension N (N x N weights, N-element vectors), range 2..8.
REQ-002 Parameter DATA_W, default 8: unsigned width of weights and input elements.
REQ-003 Parameter FIFO_DEPTH, default 16: input FIFO depth, power of two, >= ARRAY_SIZE.
REQ-004 Parameter BASE_ADDRESS, default 32'h3000_0000: base of the 32-byte register window.
REQ-005 Derived ACC_W = 2*DATA_W + clog2(ARRAY_SIZE): result width, zero-extended to 32 bits on read.
REQ-006 caravel_wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 caravel_wb_rst_n_i  input  1  asynchronous active-low reset.
REQ-008 caravel_wb_stb_i, caravel_wb_cyc_i, caravel_wb_we_i  input  1 each  Wishbone classic strobe/cycle/write.
REQ-009 caravel_wb_sel_i  input  4  byte select; ignored, full-word access assumed by software.
REQ-010 caravel_wb_adr_i, caravel_wb_dat_i  input  32 each  address, write data.
REQ-011 caravel_wb_ack_o  output  1  registered ack; caravel_wb_dat_o  output  32  registered read data.
REQ-012 irq_o  output  1  level, high while STATUS.done set.

Function
REQ-013 Register map (byte offsets): 0x00 CTRL (W: bit0 start, bit1 soft_clear), 0x04 STATUS (R), 0x08 WEIGHT (W), 0x0C INPUT (W), 0x10 RESULT (R); 0x14-0x1C read 0, writes ignored.
REQ-014 ack: one-cycle pulse the cycle after stb&cyc with address in window and ack currently low; no ack outside window; each transaction takes effect once.
REQ-015 STATUS: bit0 busy, bit1 done, bit2 fifo_full, bit3 fifo_empty, bit4 overflow (sticky), bit5 start_err (sticky), bit6 wgt_err (sticky), [15:8] fifo level, [23:16] result count.
REQ-016 WEIGHT write stores dat_i[DATA_W-1:0] at row-major index widx (row j, column k), widx increments, wraps N*N-1 -> 0.
REQ-017 WEIGHT write while busy: discarded, widx unchanged, wgt_err set.
REQ-018 INPUT write pushes dat_i[DATA_W-1:0]; when full: dropped, overflow set, level stays FIFO_DEPTH.
REQ-019 Same-cycle FIFO push (Wishbone) and pop (engine): both occur, level unchanged, FIFO order preserved.
REQ-020 Engine FSM states IDLE, LOAD, MAC, STORE.
REQ-021 IDLE -> LOAD on start when fifo level >= N; start with level < N: ignored, start_err set; start while busy: ignored, no flag.
REQ-022 LOAD: pops one element per cycle into x[0..N-1], N cycles, then MAC.
REQ-023 MAC: N cycles; cycle k all N lanes compute acc[j] += W[j][k]*x[k], acc cleared on LOAD entry; then STORE.
REQ-024 STORE: one cycle, copies acc[0..N-1] to result buffer, result count = N, sets done, -> IDLE.
REQ-025 busy high in LOAD, MAC, STORE; done cleared by accepted start or soft_clear.
REQ-026 Latency: done visible 2N+2 cycles after the start write is acked.
REQ-027 RESULT read returns result[rptr] and advances rptr; with result count 0 returns 0, no side effect.
REQ-028 New STORE overwrites unread results and resets rptr to 0.
REQ-029 soft_clear: flush FIFO, widx=0, result count=0, sticky bits cleared, done cleared, FSM -> IDLE from any state (aborts computation); weights retained.
REQ-030 start and soft_clear in same write: soft_clear wins, start ignored.
REQ-031 Arithmetic unsigned; ACC_W guarantees no overflow.

Reset
REQ-032 Reset asserted: FSM IDLE, FIFO empty, widx=0, rptr=0, result count 0, sticky bits 0, weights 0, ack_o 0, dat_o 0, irq_o 0, asynchronously.
REQ-033 Reset deasserted: operation resumes on the first subsequent rising edge; reset mid-computation discards all state.

Verification (N=3, DATA_W=8, FIFO_DEPTH=16)
REQ-034 Identity weights, INPUT 1,2,3, start -> done after 8 cycles, irq_o=1, RESULT reads 1,2,3, then 0.
REQ-035 All weights 255, inputs 255,255,255 -> each result 195075 (0x2FA03).
REQ-036 17 INPUT writes -> STATUS level 16, overflow=1, 17th value never consumed.
REQ-037 2 INPUT writes then start -> start_err=1, busy stays 0; third write + start -> completes normally.
REQ-038 soft_clear during MAC -> busy=0, done=0, result count 0, level 0; weights unchanged on next run.
REQ-039 WEIGHT write during busy -> wgt_err=1, next run results use old weights; async reset mid-LOAD -> all outputs 0 immediately.
